axi_status_responder: RTL and testbench
=======================================

Name: axi_status_responder

Overview:
- AXI4 read responder (slave) on the board AXI interconnect. It answers single-beat and burst reads from initiator blocks with a small bank of status words: board switches, free-running cycle counter, device ID and completed-read counter.
- Writes are drained and refused with SLVERR so an initiator never hangs.
- Occupies a 4 KB window at BASE_ADDR.

Parameters:
- BASE_ADDR, 64'hBC00_0000, byte base of the 4 KB window; the interconnect routes only this range here.
- DEVICE_ID, 64'hD15C_0000_0000_0001, constant returned at offset 0x10.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- sw_i  in  8  board switches, asynchronous to clk_i.
- axi_req_i  in  ariane_axi::req_t  AXI request from interconnect (ar, aw, w, valids, r_ready, b_ready).
- axi_resp_o  out  ariane_axi::resp_t  AXI response (ar_ready, aw_ready, w_ready, r, r_valid, b, b_valid); unused fields driven 0.

Behaviour:
Reset and general rules:
- All outputs are registered.
- While rst_i=1: every ready/valid is 0, r/b payloads are 0, cycle counter is 0, read counter is 0, switch synchroniser is 0, both FSMs go idle.
- Reset mid-operation abandons any burst or write response; no further beats are issued.

Register map (word offset = (addr - BASE_ADDR)[11:3], beat address aligned down to 8 bytes):
- 0x00: {56'b0, sw_sync}. sw_i passes through a 2-flop synchroniser, so it is visible in data 2 cycles after it changes.
- 0x08: 64-bit cycle counter. It increments every non-reset cycle and wraps at 2^64. Its value is sampled when a beat is loaded.
- 0x10: DEVICE_ID.
- 0x18: {32'b0, rd_count}. rd_count is a 32-bit count of completed read bursts (last-beat handshakes), wrapping at 2^32. Its value is sampled at beat load.
- Offsets 0x20..0xFFF: data 0, resp DECERR (2'b11).

Read FSM, R_IDLE:
- ar_ready=1 (from the first cycle after reset release).
- On ar_valid&ar_ready: latch id, addr, len, size, burst; go to R_BURST.
- Beat 0 is loaded into r with r_valid=1 on the next cycle (latency 1).

Read FSM, R_BURST:
- ar_ready=0.
- r.id = latched id. r.last = 1 only on beat len (len+1 beats total; len 0..255).
- While r_valid&!r_ready: r payload held bit-stable, including the counter snapshot.
- On r_valid&r_ready with beats remaining: next beat is loaded the following cycle, giving back-to-back, one beat per cycle under constant r_ready.
- On the last-beat handshake: rd_count+1, r_valid=0, return to R_IDLE; ar_ready=1 the following cycle. There is no AR overlap.

Burst types:
- FIXED (0): address constant for all beats.
- INCR (1): address += (1<<size) per beat; data is always the full aligned 64-bit word.
- WRAP (2) or reserved (3): all len+1 beats return data 0, resp SLVERR (2'b10).

Response codes:
- Mapped offsets with FIXED/INCR: resp OKAY (2'b00).
- Precedence: burst error > decode error.

Write FSM (independent of reads; both run concurrently):
- W_IDLE: aw_ready=1, w_ready=0. On AW handshake, latch aw.id and go to W_DATA.
- W_DATA: aw_ready=0, w_ready=1. Discard beats; on the w_valid&w.last handshake go to W_RESP.
- W_RESP: b_valid=1, b.id = latched id, b.resp=SLVERR. Hold until b_ready, then go to W_IDLE.
- W beats presented before AW stall, because w_ready=0 in W_IDLE.

Test Plan:
1. Reset 4 cycles, then AR addr 0xBC000010 len 0 id 1 FIXED, r_ready=1 -> r_valid in the cycle after the AR handshake; data 0xD15C000000000001, resp 00, last 1, id 1; ar_ready=1 the next cycle.
2. sw_i=0xA5; AR INCR len 3 at 0xBC000000 size 3, r_ready toggled 1/0 -> 4 beats: 0xA5, cycle snapshot, DEVICE_ID, 0. Each payload is stable across stall cycles; last asserted only on beat 4. A following single read at 0x18 returns 1.
3. AR FIXED len 2 at 0xBC000008, r_ready=1 -> 3 consecutive beats with counter values n, n+1, n+2.
4. AR INCR len 0 at 0xBC000040 -> data 0, resp 11. AR WRAP len 1 at 0xBC000000 -> 2 beats, data 0, resp 10 each, last on beat 2.
5. AW id 2, then 3 W beats (last on 3rd) with b_ready held 0 for 5 cycles, while an INCR len 1 read runs concurrently -> b_valid held with id 2, resp 10 until b_ready. The read completes unaffected.
6. rst_i pulsed for 1 cycle during beat 2 of a 4-beat burst -> r_valid=0 in the reset cycle; ar_ready=1 the next cycle; no residual beats; read at 0x18 returns 0.

Source files
------------

// File: rtl/ariane_axi.sv
// AXI4 channel and bundle types shared by the board interconnect.
package ariane_axi;

    localparam int unsigned IdWidth   = 4;
    localparam int unsigned AddrWidth = 64;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned UserWidth = 1;

    typedef logic [IdWidth-1:0]   id_t;
    typedef logic [AddrWidth-1:0] addr_t;
    typedef logic [DataWidth-1:0] data_t;
    typedef logic [StrbWidth-1:0] strb_t;
    typedef logic [UserWidth-1:0] user_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        logic [5:0] atop;
        user_t      user;
    } aw_chan_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
        user_t user;
    } w_chan_t;

    typedef struct packed {
        id_t        id;
        logic [1:0] resp;
        user_t      user;
    } b_chan_t;

    typedef struct packed {
        id_t        id;
        addr_t      addr;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        logic       lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        user_t      user;
    } ar_chan_t;

    typedef struct packed {
        id_t        id;
        data_t      data;
        logic [1:0] resp;
        logic       last;
        user_t      user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;

endpackage

// File: rtl/axi_status_responder.sv
// AXI4 read-only status window: switches, cycle counter, device ID, read count.
// Writes are accepted, discarded and answered with SLVERR.
module axi_status_responder #(
    parameter logic [63:0] BASE_ADDR = 64'hBC00_0000,
    parameter logic [63:0] DEVICE_ID = 64'hD15C_0000_0000_0001
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        sw_i,
    input  ariane_axi::req_t  axi_req_i,
    output ariane_axi::resp_t axi_resp_o
);

    localparam int unsigned SwWidth    = 8;
    localparam int unsigned CntWidth   = 64;
    localparam int unsigned RdCntWidth = 32;
    localparam int unsigned WordWidth  = 9;
    localparam int unsigned LenWidth   = 8;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] RespDecerr = 2'b11;
    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;

    typedef enum logic {R_IDLE, R_BURST} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    logic [SwWidth-1:0]    sw_meta_q, sw_sync_q;
    logic [CntWidth-1:0]   cycle_cnt_q;
    logic [RdCntWidth-1:0] rd_count_q, rd_count_d;

    r_state_e              r_state_q, r_state_d;
    logic                  ar_ready_q, ar_ready_d;
    logic                  r_valid_q, r_valid_d;
    ariane_axi::r_chan_t   r_q, r_d;
    ariane_axi::id_t       id_q, id_d;
    ariane_axi::addr_t     addr_q, addr_d;
    logic [LenWidth-1:0]   len_q, len_d;
    logic [LenWidth-1:0]   beat_q, beat_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    ariane_axi::addr_t     next_addr;

    w_state_e              w_state_q, w_state_d;
    logic                  aw_ready_q, aw_ready_d;
    logic                  w_ready_q, w_ready_d;
    logic                  b_valid_q, b_valid_d;
    ariane_axi::b_chan_t   b_q, b_d;

    logic                  unused_req;

    // Build one read beat from the register map; a bad burst type overrides decode.
    function automatic ariane_axi::r_chan_t load_beat(
        input ariane_axi::id_t       id,
        input ariane_axi::addr_t     addr,
        input logic [1:0]            burst,
        input logic                  last,
        input logic [SwWidth-1:0]    sw,
        input logic [CntWidth-1:0]   cnt,
        input logic [RdCntWidth-1:0] rdc
    );
        ariane_axi::r_chan_t beat;
        logic [WordWidth-1:0] word;
        beat      = '0;
        beat.id   = id;
        beat.last = last;
        word      = WordWidth'((addr - BASE_ADDR) >> 3);
        if (burst != BurstFixed && burst != BurstIncr) begin
            beat.resp = RespSlverr;
        end else begin
            beat.resp = RespOkay;
            case (word)
                WordWidth'(0): beat.data = 64'(sw);
                WordWidth'(1): beat.data = cnt;
                WordWidth'(2): beat.data = DEVICE_ID;
                WordWidth'(3): beat.data = 64'(rdc);
                default:       beat.resp = RespDecerr;
            endcase
        end
        return beat;
    endfunction

    // Switch synchroniser and free-running cycle counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sw_meta_q   <= '0;
            sw_sync_q   <= '0;
            cycle_cnt_q <= '0;
        end else begin
            sw_meta_q   <= sw_i;
            sw_sync_q   <= sw_meta_q;
            cycle_cnt_q <= cycle_cnt_q + CntWidth'(1);
        end
    end

    // Read FSM state and registered AR/R outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q  <= R_IDLE;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_q        <= '0;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            rd_count_q <= '0;
        end else begin
            r_state_q  <= r_state_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            r_q        <= r_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
            rd_count_q <= rd_count_d;
        end
    end

    // Read FSM next state: accept AR, then stream len+1 beats, one per r handshake.
    always_comb begin
        r_state_d  = r_state_q;
        ar_ready_d = ar_ready_q;
        r_valid_d  = r_valid_q;
        r_d        = r_q;
        id_d       = id_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_d     = beat_q;
        size_d     = size_q;
        burst_d    = burst_q;
        rd_count_d = rd_count_q;
        next_addr  = (burst_q == BurstFixed) ? addr_q
                                             : addr_q + (ariane_axi::AddrWidth'(1) << size_q);
        case (r_state_q)
            R_IDLE: begin
                ar_ready_d = 1'b1;
                r_valid_d  = 1'b0;
                if (axi_req_i.ar_valid && ar_ready_q) begin
                    r_state_d  = R_BURST;
                    ar_ready_d = 1'b0;
                    r_valid_d  = 1'b1;
                    id_d       = axi_req_i.ar.id;
                    addr_d     = axi_req_i.ar.addr;
                    len_d      = axi_req_i.ar.len;
                    size_d     = axi_req_i.ar.size;
                    burst_d    = axi_req_i.ar.burst;
                    beat_d     = '0;
                    r_d        = load_beat(axi_req_i.ar.id, axi_req_i.ar.addr,
                                           axi_req_i.ar.burst, axi_req_i.ar.len == '0,
                                           sw_sync_q, cycle_cnt_q, rd_count_q);
                end
            end
            R_BURST: begin
                ar_ready_d = 1'b0;
                if (r_valid_q && axi_req_i.r_ready) begin
                    if (beat_q == len_q) begin
                        r_state_d  = R_IDLE;
                        ar_ready_d = 1'b1;
                        r_valid_d  = 1'b0;
                        r_d        = '0;
                        rd_count_d = rd_count_q + RdCntWidth'(1);
                    end else begin
                        addr_d = next_addr;
                        beat_d = beat_q + LenWidth'(1);
                        r_d    = load_beat(id_q, next_addr, burst_q,
                                           (beat_q + LenWidth'(1)) == len_q,
                                           sw_sync_q, cycle_cnt_q, rd_count_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Write FSM state and registered AW/W/B outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_q  <= W_IDLE;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_q        <= '0;
        end else begin
            w_state_q  <= w_state_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
            b_q        <= b_d;
        end
    end

    // Write FSM next state: take AW, swallow W up to last, then hold SLVERR until b_ready.
    always_comb begin
        w_state_d  = w_state_q;
        aw_ready_d = aw_ready_q;
        w_ready_d  = w_ready_q;
        b_valid_d  = b_valid_q;
        b_d        = b_q;
        case (w_state_q)
            W_IDLE: begin
                aw_ready_d = 1'b1;
                w_ready_d  = 1'b0;
                b_valid_d  = 1'b0;
                if (axi_req_i.aw_valid && aw_ready_q) begin
                    w_state_d  = W_DATA;
                    aw_ready_d = 1'b0;
                    w_ready_d  = 1'b1;
                    b_d.id     = axi_req_i.aw.id;
                    b_d.resp   = RespSlverr;
                end
            end
            W_DATA: begin
                aw_ready_d = 1'b0;
                w_ready_d  = 1'b1;
                if (axi_req_i.w_valid && w_ready_q && axi_req_i.w.last) begin
                    w_state_d = W_RESP;
                    w_ready_d = 1'b0;
                    b_valid_d = 1'b1;
                end
            end
            W_RESP: begin
                aw_ready_d = 1'b0;
                w_ready_d  = 1'b0;
                b_valid_d  = 1'b1;
                if (axi_req_i.b_ready && b_valid_q) begin
                    w_state_d  = W_IDLE;
                    aw_ready_d = 1'b1;
                    b_valid_d  = 1'b0;
                    b_d        = '0;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Response bundle is a pure repackaging of registers; unused fields stay 0.
    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.ar_ready = ar_ready_q;
        axi_resp_o.r_valid  = r_valid_q;
        axi_resp_o.r        = r_q;
        axi_resp_o.aw_ready = aw_ready_q;
        axi_resp_o.w_ready  = w_ready_q;
        axi_resp_o.b_valid  = b_valid_q;
        axi_resp_o.b        = b_q;
    end

    // Request fields this responder has no use for.
    assign unused_req = ^{axi_req_i.ar.lock, axi_req_i.ar.cache, axi_req_i.ar.prot,
                          axi_req_i.ar.qos, axi_req_i.ar.region, axi_req_i.ar.user,
                          axi_req_i.aw.addr, axi_req_i.aw.len, axi_req_i.aw.size,
                          axi_req_i.aw.burst, axi_req_i.aw.lock, axi_req_i.aw.cache,
                          axi_req_i.aw.prot, axi_req_i.aw.qos, axi_req_i.aw.region,
                          axi_req_i.aw.atop, axi_req_i.aw.user, axi_req_i.w.data,
                          axi_req_i.w.strb, axi_req_i.w.user};

endmodule

// File: tb/tb_axi_status_responder.sv
// Directed bench for axi_status_responder.
module tb_axi_status_responder;

    localparam logic [63:0] BASE  = 64'hBC00_0000;
    localparam logic [63:0] DEVID = 64'hD15C_0000_0000_0001;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [7:0]        sw_i;
    ariane_axi::req_t  req;
    ariane_axi::resp_t resp;

    int n_vec  = 0;
    int n_miss = 0;

    logic [63:0] cyc_model;
    logic [63:0] bd [16];
    logic [1:0]  br [16];
    logic        bl [16];
    logic [3:0]  bid[16];
    logic [63:0] bs [16];
    int          nbeats;
    logic        first_rv;

    axi_status_responder #(
        .BASE_ADDR(BASE),
        .DEVICE_ID(DEVID)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .sw_i      (sw_i),
        .axi_req_i (req),
        .axi_resp_o(resp)
    );

    always #5 clk_i = ~clk_i;

    // Reference cycle counter: value after each edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) cyc_model <= '0;
        else       cyc_model <= cyc_model + 64'd1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_i = 1'b1;
        repeat (cycles) step();
        rst_i = 1'b0;
        repeat (3) step();
    endtask

    task automatic issue_ar(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id);
        bit hs;
        int guard;
        req.ar.addr  = addr;
        req.ar.len   = len;
        req.ar.size  = size;
        req.ar.burst = burst;
        req.ar.id    = id;
        req.ar_valid = 1'b1;
        hs = 1'b0;
        guard = 0;
        while (!hs && guard < 50) begin
            hs = resp.ar_ready;
            step();
            guard++;
        end
        req.ar_valid = 1'b0;
        check("ar_handshake", 64'(hs), 64'd1);
    endtask

    task automatic axi_read(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id, input bit toggle);
        int          guard;
        bit          hs, rdy, stalled;
        logic [63:0] held_data;
        logic [6:0]  held_side;
        issue_ar(addr, len, size, burst, id);
        first_rv = resp.r_valid;
        nbeats   = 0;
        stalled  = 1'b0;
        rdy      = !toggle;
        guard    = 0;
        while (nbeats <= int'(len) && guard < 2000) begin
            if (resp.r_valid) begin
                if (stalled) begin
                    check("stall_data", resp.r.data, held_data);
                    check("stall_side", 64'({resp.r.id, resp.r.resp, resp.r.last}), 64'(held_side));
                end else if (nbeats < 16) begin
                    bd[nbeats]  = resp.r.data;
                    br[nbeats]  = resp.r.resp;
                    bl[nbeats]  = resp.r.last;
                    bid[nbeats] = resp.r.id;
                    bs[nbeats]  = cyc_model - 64'd1;
                end
                held_data = resp.r.data;
                held_side = {resp.r.id, resp.r.resp, resp.r.last};
            end
            req.r_ready = rdy;
            hs      = resp.r_valid && rdy;
            stalled = resp.r_valid && !rdy;
            step();
            if (hs) nbeats++;
            if (toggle) rdy = !rdy;
            guard++;
        end
        req.r_ready = 1'b0;
        check("beat_count", 64'(nbeats), 64'(len) + 64'd1);
    endtask

    task automatic write_seq();
        bit hs;
        int guard;
        req.w.last  = 1'b0;
        req.w_valid = 1'b1;
        step();
        check("w_stall_a", 64'(resp.w_ready), 64'd0);
        step();
        check("w_stall_b", 64'(resp.w_ready), 64'd0);
        req.aw.id    = 4'd2;
        req.aw_valid = 1'b1;
        hs = 1'b0;
        guard = 0;
        while (!hs && guard < 50) begin
            hs = resp.aw_ready;
            step();
            guard++;
        end
        req.aw_valid = 1'b0;
        check("aw_handshake", 64'(hs), 64'd1);
        check("aw_ready_drop", 64'(resp.aw_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            req.w.data  = 64'(i) * 64'h1111;
            req.w.last  = (i == 2);
            req.w_valid = 1'b1;
            hs = 1'b0;
            guard = 0;
            while (!hs && guard < 50) begin
                hs = resp.w_ready;
                step();
                guard++;
            end
            check("w_handshake", 64'(hs), 64'd1);
        end
        req.w_valid = 1'b0;
        req.b_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("b_valid_hold", 64'(resp.b_valid), 64'd1);
            check("b_id", 64'(resp.b.id), 64'd2);
            check("b_resp", 64'(resp.b.resp), 64'd2);
            step();
        end
        req.b_ready = 1'b1;
        check("b_valid_pre", 64'(resp.b_valid), 64'd1);
        step();
        req.b_ready = 1'b0;
        check("b_valid_done", 64'(resp.b_valid), 64'd0);
        check("aw_ready_back", 64'(resp.aw_ready), 64'd1);
    endtask

    initial begin
        req   = '0;
        sw_i  = 8'h00;
        rst_i = 1'b1;

        // Reset state
        step();
        step();
        check("rst_ar_ready", 64'(resp.ar_ready), 64'd0);
        check("rst_r_valid", 64'(resp.r_valid), 64'd0);
        check("rst_aw_ready", 64'(resp.aw_ready), 64'd0);
        check("rst_b_valid", 64'(resp.b_valid), 64'd0);
        check("rst_r_data", resp.r.data, 64'd0);
        do_reset(2);

        // 1: single-beat device ID read
        axi_read(BASE + 64'h10, 8'd0, 3'd3, 2'b00, 4'd1, 1'b0);
        check("t1_latency", 64'(first_rv), 64'd1);
        check("t1_data", bd[0], DEVID);
        check("t1_resp", 64'(br[0]), 64'd0);
        check("t1_last", 64'(bl[0]), 64'd1);
        check("t1_id", 64'(bid[0]), 64'd1);
        check("t1_rvalid_off", 64'(resp.r_valid), 64'd0);
        check("t1_ar_ready", 64'(resp.ar_ready), 64'd1);

        // 2: INCR burst with r_ready toggling
        sw_i = 8'hA5;
        do_reset(1);
        axi_read(BASE, 8'd3, 3'd3, 2'b01, 4'd5, 1'b1);
        check("t2_b0", bd[0], 64'hA5);
        check("t2_b1", bd[1], bs[1]);
        check("t2_b2", bd[2], DEVID);
        check("t2_b3", bd[3], 64'd0);
        for (int i = 0; i < 4; i++) begin
            check("t2_resp", 64'(br[i]), 64'd0);
            check("t2_last", 64'(bl[i]), (i == 3) ? 64'd1 : 64'd0);
            check("t2_id", 64'(bid[i]), 64'd5);
        end
        axi_read(BASE + 64'h18, 8'd0, 3'd3, 2'b00, 4'd0, 1'b0);
        check("t2_rdcount", bd[0], 64'd1);

        // 3: FIXED counter burst, back to back
        axi_read(BASE + 64'h08, 8'd2, 3'd3, 2'b00, 4'd3, 1'b0);
        check("t3_b0", bd[0], bs[0]);
        check("t3_b1", bd[1], bs[0] + 64'd1);
        check("t3_b2", bd[2], bs[0] + 64'd2);

        // 4: decode error and unsupported burst
        axi_read(BASE + 64'h40, 8'd0, 3'd3, 2'b01, 4'd4, 1'b0);
        check("t4_dec_data", bd[0], 64'd0);
        check("t4_dec_resp", 64'(br[0]), 64'd3);
        axi_read(BASE, 8'd1, 3'd3, 2'b10, 4'd6, 1'b0);
        for (int i = 0; i < 2; i++) begin
            check("t4_wrap_data", bd[i], 64'd0);
            check("t4_wrap_resp", 64'(br[i]), 64'd2);
            check("t4_wrap_last", 64'(bl[i]), (i == 1) ? 64'd1 : 64'd0);
        end

        // 5: refused write concurrent with a read
        fork
            write_seq();
            axi_read(BASE + 64'h10, 8'd1, 3'd3, 2'b01, 4'd7, 1'b0);
        join
        check("t5_rd_b0", bd[0], DEVID);
        check("t5_rd_b1", bd[1], 64'd5);
        check("t5_rd_last", 64'(bl[1]), 64'd1);
        check("t5_rd_id", 64'(bid[1]), 64'd7);

        // 6: reset in the middle of a burst
        issue_ar(BASE, 8'd3, 3'd3, 2'b01, 4'd9);
        req.r_ready = 1'b1;
        check("t6_beat1", 64'(resp.r_valid), 64'd1);
        step();
        check("t6_beat2", 64'(resp.r_valid), 64'd1);
        rst_i = 1'b1;
        step();
        check("t6_rst_rvalid", 64'(resp.r_valid), 64'd0);
        check("t6_rst_arready", 64'(resp.ar_ready), 64'd0);
        check("t6_rst_data", resp.r.data, 64'd0);
        rst_i = 1'b0;
        step();
        check("t6_ar_ready", 64'(resp.ar_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            check("t6_no_residual", 64'(resp.r_valid), 64'd0);
            step();
        end
        req.r_ready = 1'b0;
        axi_read(BASE + 64'h18, 8'd0, 3'd3, 2'b00, 4'd0, 1'b0);
        check("t6_rdcount", bd[0], 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
